gfm: RTL and testbench

GFM -- requirements
Module: gfm

---
 rtl/gfm_step.sv | 21 ++
 rtl/gfm.sv | 91 +++++++++
 tb/tb_gfm.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gfm_step.sv
// One MSB-first shift-and-add step of GF(2^GFM_BITS) multiplication:
// new_acc = (acc * x mod POLYNOMIAL) ^ (b_bit ? a : 0).
module gfm_step #(
    parameter int unsigned         GFM_BITS   = 128,
    parameter logic [GFM_BITS:0]   POLYNOMIAL = 129'h100000000000000000000000000000087
) (
    input  logic [GFM_BITS-1:0] acc,
    input  logic [GFM_BITS-1:0] a,
    input  logic                b_bit,
    output logic [GFM_BITS-1:0] new_acc
);

    logic [GFM_BITS-1:0] shifted;

    always_comb begin
        // x^GFM_BITS folds back as the low bits of the polynomial
        shifted = {acc[GFM_BITS-2:0], 1'b0} ^ (acc[GFM_BITS-1] ? POLYNOMIAL[GFM_BITS-1:0] : '0);
        new_acc = shifted ^ (b_bit ? a : '0);
    end

endmodule

// File: rtl/gfm.sv
// Iterative GF(2^GFM_BITS) multiplier: GFM_BITS/GFM_CYCLES unrolled steps per
// clock, IDLE -> BUSY -> DONE controller with a one-cycle done pulse.
module gfm #(
    parameter int unsigned         GFM_BITS   = 128,
    parameter int unsigned         GFM_CYCLES = 8,
    parameter logic [GFM_BITS:0]   POLYNOMIAL = 129'h100000000000000000000000000000087
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [GFM_BITS-1:0] a,
    input  logic [GFM_BITS-1:0] b,
    output logic [GFM_BITS-1:0] result,
    output logic                done
);

    localparam int unsigned STEPS = GFM_BITS / GFM_CYCLES;
    localparam int unsigned CW    = (GFM_CYCLES > 1) ? $clog2(GFM_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [GFM_BITS-1:0] acc;
    logic [GFM_BITS-1:0] a_reg;
    logic [GFM_BITS-1:0] b_reg;
    logic [GFM_BITS-1:0] chain [0:STEPS];

    assign chain[0] = acc;

    // b_reg is shifted left each cycle, so its top STEPS bits are always next
    for (genvar j = 0; j < STEPS; j++) begin : g_step
        gfm_step #(
            .GFM_BITS   (GFM_BITS),
            .POLYNOMIAL (POLYNOMIAL)
        ) u_step (
            .acc     (chain[j]),
            .a       (a_reg),
            .b_bit   (b_reg[GFM_BITS-1-j]),
            .new_acc (chain[j+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= chain[STEPS];
                    b_reg <= b_reg << STEPS;
                    count <= count + 1'b1;
                    if (count == CW'(GFM_CYCLES - 1)) begin
                        result <= chain[STEPS];
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfm.sv
// Directed bench for gfm: known products, latency, reset abort, back-to-back.
module tb_gfm;

    logic         clk;
    logic         reset;
    logic         en;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] result;
    logic         done;

    int checks = 0;
    int errors = 0;

    gfm #(
        .GFM_BITS   (128),
        .GFM_CYCLES (8),
        .POLYNOMIAL (129'h100000000000000000000000000000087)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic run_mul(input logic [127:0] ta, input logic [127:0] tb_val,
                           input logic [127:0] exp, input bit hold_en, input string tag);
        int lat;
        a  = ta;
        b  = tb_val;
        en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_en) en = 1'b0;
        a   = ~ta;
        b   = tb_val ^ 128'h5a5a;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd8);
        check({tag, "_done"}, {127'd0, done}, 128'd1);
        check({tag, "_result"}, result, exp);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_clear"}, {127'd0, done}, 128'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b0;
        en    = 1'b1;
        a     = '1;
        b     = '1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", {127'd0, done}, 128'd0);
        check("reset_result", result, 128'd0);
        en    = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_done", {127'd0, done}, 128'd0);

        run_mul(128'h7b5b54657374566563746f725d53475d, 128'h48692853686179295b477565726f6e5d,
                128'h040229a09a5ed12e7e4e10da323506d2, 1'b0, "vector");
        run_mul(128'h0123456789abcdeffedcba9876543210, 128'd1,
                128'h0123456789abcdeffedcba9876543210, 1'b0, "b_one");
        run_mul(128'hdeadbeefcafebabe0011223344556677, 128'd0, 128'd0, 1'b0, "b_zero");
        run_mul(128'h80000000000000000000000000000000, 128'd2, 128'h87, 1'b0, "wrap");

        // en held high through BUSY/DONE must not restart or extend the pulse
        run_mul(128'd3, 128'd5, 128'hf, 1'b1, "hold_en");
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("hold_no_extra_pulse", 128'(pulses), 128'd0);

        // Reset during BUSY, with en asserted while reset is low
        a  = 128'hff;
        b  = 128'hff;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        en    = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", 128'(pulses), 128'd0);
        check("abort_result", result, 128'd0);

        // Back-to-back: second en in the first IDLE cycle after DONE
        run_mul(128'hff, 128'hff, 128'h5555, 1'b0, "b2b_first");
        run_mul(128'h80000000000000000000000000000000, 128'd4, 128'h10e, 1'b0, "b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
